// File: rtl/pc_ras_unit_if.sv
// Fetch-side bundle for pc_ras_unit: next-PC controls in, PC and RAS status out.
interface pc_ras_unit_if;
  logic        en;
  logic [2:0]  pcsrc;
  logic [31:0] reg_target;
  logic [25:0] imm26;
  logic [31:0] imm32;
  logic        flush;
  logic [31:0] pc;
  logic [31:0] npc;
  logic [31:0] ras_top;
  logic [4:0]  ras_cnt;
  logic        ras_ovf;
  logic        ras_unf;
  logic        illegal;

  modport master (
    output en, pcsrc, reg_target, imm26, imm32, flush,
    input  pc, npc, ras_top, ras_cnt, ras_ovf, ras_unf, illegal
  );
  modport slave (
    input  en, pcsrc, reg_target, imm26, imm32, flush,
    output pc, npc, ras_top, ras_cnt, ras_ovf, ras_unf, illegal
  );
endinterface

// File: rtl/pc_ras_unit.sv
// Program counter with next-PC select and a circular return-address stack.
// JAL pushes the link address; RAS-select pops it, falling back to reg_target.
module pc_ras_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          RAS_DEPTH = 4,
  parameter int          RAS_EN    = 1
) (
  input  logic          CLK,
  input  logic          nRST,
  pc_ras_unit_if.slave  bus
);
  typedef enum logic [2:0] {
    PCSRC_CPC = 3'd0,
    PCSRC_NPC = 3'd1,
    PCSRC_REG = 3'd2,
    PCSRC_JAL = 3'd3,
    PCSRC_IMM = 3'd4,
    PCSRC_RAS = 3'd5
  } pcsrc_t;

  logic [31:0] pc_q, pc_nxt, npc, ras_top;
  logic [4:0]  ras_cnt;
  logic        push, pop, unf_set, rsv, illegal_q;
  logic        ras_on;

  assign ras_on  = (RAS_EN != 0);
  assign npc     = pc_q + 32'd4;
  assign bus.pc  = pc_q;
  assign bus.npc = npc;
  assign bus.ras_top = ras_top;
  assign bus.ras_cnt = ras_cnt;
  assign bus.illegal = illegal_q;

  always_comb begin
    pc_nxt  = pc_q;
    push    = 1'b0;
    pop     = 1'b0;
    unf_set = 1'b0;
    rsv     = 1'b0;
    if (bus.en) begin
      case (pcsrc_t'(bus.pcsrc))
        PCSRC_CPC: pc_nxt = pc_q;
        PCSRC_NPC: pc_nxt = npc;
        PCSRC_REG: pc_nxt = bus.reg_target;
        PCSRC_JAL: begin
          pc_nxt = {npc[31:28], bus.imm26, 2'b00};
          push   = ras_on && !bus.flush;
        end
        PCSRC_IMM: pc_nxt = npc + {bus.imm32[29:0], 2'b00};
        PCSRC_RAS: begin
          // Flush empties the stack this edge, so the pop never happens.
          if (ras_on && !bus.flush && ras_cnt != 5'd0) begin
            pc_nxt = ras_top;
            pop    = 1'b1;
          end else begin
            pc_nxt  = bus.reg_target;
            unf_set = ras_on && !bus.flush;
          end
        end
        default: rsv = 1'b1;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      pc_q      <= RESET_PC;
      illegal_q <= 1'b0;
    end else begin
      if (bus.en) pc_q <= pc_nxt;
      illegal_q <= rsv;
    end
  end

  generate
    if (RAS_EN != 0) begin : g_ras
      localparam int          PW    = $clog2(RAS_DEPTH);
      localparam logic [4:0]  DEPTH = 5'(RAS_DEPTH);

      logic [31:0]   mem [RAS_DEPTH];
      logic [PW-1:0] sp, sp_inc, sp_dec;
      logic [4:0]    cnt;
      logic          ovf, unf;

      // Power-of-two depth: pointer wraps naturally, so a full push lands on the oldest entry.
      assign sp_inc = sp + 1'b1;
      assign sp_dec = sp - 1'b1;

      always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
          sp  <= '0;
          cnt <= 5'd0;
          ovf <= 1'b0;
          unf <= 1'b0;
        end else begin
          if (bus.flush) begin
            cnt <= 5'd0;
          end else if (push) begin
            sp <= sp_inc;
            if (cnt == DEPTH) ovf <= 1'b1;
            else              cnt <= cnt + 5'd1;
          end else if (pop) begin
            sp  <= sp_dec;
            cnt <= cnt - 5'd1;
          end
          if (unf_set) unf <= 1'b1;
        end
      end

      always_ff @(posedge CLK) begin
        if (push) mem[sp_inc] <= npc;
      end

      assign ras_top     = (cnt == 5'd0) ? 32'd0 : mem[sp];
      assign ras_cnt     = cnt;
      assign bus.ras_ovf = ovf;
      assign bus.ras_unf = unf;
    end else begin : g_no_ras
      assign ras_top     = 32'd0;
      assign ras_cnt     = 5'd0;
      assign bus.ras_ovf = 1'b0;
      assign bus.ras_unf = 1'b0;
    end
  endgenerate
endmodule

// File: tb/tb_pc_ras_unit.sv
// Directed vectors for pc_ras_unit with hand-computed expectations.
module tb_pc_ras_unit;
  logic CLK = 1'b0;
  logic nRST = 1'b0;
  int   n_run = 0;
  int   n_fail = 0;

  pc_ras_unit_if bus ();

  pc_ras_unit #(.RESET_PC(32'h0), .RAS_DEPTH(4), .RAS_EN(1)) dut (
    .CLK (CLK),
    .nRST(nRST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic [2:0] src, input logic [31:0] tgt, input logic [25:0] i26,
                       input logic [31:0] i32);
    bus.en = 1'b1; bus.pcsrc = src; bus.reg_target = tgt; bus.imm26 = i26; bus.imm32 = i32;
    step();
  endtask

  initial begin
    bus.en = 1'b0; bus.pcsrc = 3'd0; bus.reg_target = '0;
    bus.imm26 = '0; bus.imm32 = '0; bus.flush = 1'b0;
    #2;
    chk("rst_pc", bus.pc, 32'h0);
    chk("rst_cnt", 32'(bus.ras_cnt), 32'd0);
    chk("rst_ovf", 32'(bus.ras_ovf), 32'd0);
    chk("rst_unf", 32'(bus.ras_unf), 32'd0);
    chk("rst_ill", 32'(bus.illegal), 32'd0);
    chk("rst_top", bus.ras_top, 32'd0);
    #10 nRST = 1'b1;

    // sequential fetch
    drive(3'd1, 0, 0, 0); chk("npc_1", bus.pc, 32'h4);
    drive(3'd1, 0, 0, 0); chk("npc_2", bus.pc, 32'h8);
    drive(3'd1, 0, 0, 0); chk("npc_3", bus.pc, 32'hC);

    // JAL then return
    drive(3'd2, 32'h0040_0010, 0, 0); chk("reg_ld", bus.pc, 32'h0040_0010);
    drive(3'd3, 0, 26'h0000100, 0);
    chk("jal_pc", bus.pc, 32'h0000_0400);
    chk("jal_top", bus.ras_top, 32'h0040_0014);
    chk("jal_cnt", 32'(bus.ras_cnt), 32'd1);
    drive(3'd5, 32'h1234_5678, 0, 0);
    chk("ret_pc", bus.pc, 32'h0040_0014);
    chk("ret_cnt", 32'(bus.ras_cnt), 32'd0);
    chk("ret_top", bus.ras_top, 32'd0);

    // five calls into a 4-deep stack, link Ai = 0x1000*i + 4
    for (int i = 1; i <= 5; i++) begin
      drive(3'd2, 32'h1000 * i, 0, 0);
      drive(3'd3, 0, 26'h40, 0);
      if (i == 4) begin
        chk("fill_cnt", 32'(bus.ras_cnt), 32'd4);
        chk("fill_ovf", 32'(bus.ras_ovf), 32'd0);
      end
    end
    chk("ovf_cnt", 32'(bus.ras_cnt), 32'd4);
    chk("ovf_flag", 32'(bus.ras_ovf), 32'd1);
    chk("ovf_top", bus.ras_top, 32'h5004);
    for (int i = 5; i >= 2; i--) begin
      drive(3'd5, 32'hFFFF_0000, 0, 0);
      chk("pop_pc", bus.pc, 32'h1000 * i + 32'h4);
    end
    chk("pop_cnt", 32'(bus.ras_cnt), 32'd0);
    chk("pre_unf", 32'(bus.ras_unf), 32'd0);
    drive(3'd5, 32'hDEAD_BEE0, 0, 0);
    chk("unf_pc", bus.pc, 32'hDEAD_BEE0);
    chk("unf_flag", 32'(bus.ras_unf), 32'd1);
    chk("unf_cnt", 32'(bus.ras_cnt), 32'd0);

    // branch offset and wrap
    drive(3'd2, 32'h100, 0, 0);
    drive(3'd4, 0, 0, 32'hFFFF_FFFE); chk("imm_neg", bus.pc, 32'h0FC);
    drive(3'd2, 32'hFFFF_FFFC, 0, 0); chk("npc_wrap_c", bus.npc, 32'h0);
    drive(3'd1, 0, 0, 0); chk("pc_wrap", bus.pc, 32'h0);

    // flush leaves sticky flags alone
    bus.en = 1'b0; bus.flush = 1'b1; step(); bus.flush = 1'b0;
    chk("fl_ovf", 32'(bus.ras_ovf), 32'd1);
    chk("fl_unf", 32'(bus.ras_unf), 32'd1);

    // hold while disabled, then reserved select
    drive(3'd3, 0, 26'h40, 0); chk("hold_pre_cnt", 32'(bus.ras_cnt), 32'd1);
    bus.en = 1'b0; bus.imm26 = 26'h3FF;
    step(); step(); step();
    chk("hold_pc", bus.pc, 32'h100);
    chk("hold_cnt", 32'(bus.ras_cnt), 32'd1);
    drive(3'd6, 0, 0, 0);
    chk("rsv_pc", bus.pc, 32'h100);
    chk("rsv_ill", 32'(bus.illegal), 32'd1);
    chk("rsv_cnt", 32'(bus.ras_cnt), 32'd1);
    drive(3'd0, 0, 0, 0);
    chk("ill_clr", 32'(bus.illegal), 32'd0);
    chk("cpc_pc", bus.pc, 32'h100);

    // async reset between edges clears sticky flags
    #2 nRST = 1'b0; #1;
    chk("arst_pc", bus.pc, 32'h0);
    chk("arst_ovf", 32'(bus.ras_ovf), 32'd0);
    chk("arst_cnt", 32'(bus.ras_cnt), 32'd0);
    nRST = 1'b1;

    // flush with RAS select falls back to reg_target without underflow
    drive(3'd3, 0, 26'h10, 0);
    drive(3'd3, 0, 26'h10, 0);
    chk("fl2_cnt", 32'(bus.ras_cnt), 32'd2);
    bus.flush = 1'b1;
    drive(3'd5, 32'h200, 0, 0);
    bus.flush = 1'b0;
    chk("fl2_pc", bus.pc, 32'h200);
    chk("fl2_cnt0", 32'(bus.ras_cnt), 32'd0);
    chk("fl2_unf", 32'(bus.ras_unf), 32'd0);
    #2 nRST = 1'b0; #1;
    chk("rst2_pc", bus.pc, 32'h0);
    nRST = 1'b1;

    // reset held across a JAL edge wins
    drive(3'd2, 32'h800, 0, 0);
    bus.pcsrc = 3'd3; bus.imm26 = 26'h20; nRST = 1'b0;
    step();
    chk("rjal_pc", bus.pc, 32'h0);
    chk("rjal_cnt", 32'(bus.ras_cnt), 32'd0);
    #2 nRST = 1'b1;
    drive(3'd1, 0, 0, 0); chk("post_rst", bus.pc, 32'h4);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/pc_ras_unit.md
PC_RAS_UNIT -- requirements
Module: pc_ras_unit

Interface
REQ-001 SHALL expose parameter RESET_PC, default 32'h0000_0000, PC value loaded at reset.
REQ-002 SHALL expose parameter RAS_DEPTH, default 4, return-address-stack entries, legal range 2..16, power of two.
REQ-003 SHALL expose parameter RAS_EN, default 1; when 0, RAS storage is absent and PCSRC_RAS behaves as PCSRC_REG.
REQ-004 Ports:
  CLK  in  1  single clock, all state updates on rising edge
  nRST  in  1  reset, asynchronous, active-low
  en  in  1  PC update enable (fetch hit and no stall)
  pcsrc  in  3  next-PC select, pcsrc_t encoding
  reg_target  in  32  register value for jr
  imm26  in  26  jump field
  imm32  in  32  extended branch offset, word units
  flush  in  1  clear RAS (exception/mispredict recovery)
  pc  out  32  current PC
  npc  out  32  pc + 4
  ras_top  out  32  current RAS top entry, 0 when empty
  ras_cnt  out  5  valid RAS entries
  ras_ovf  out  1  sticky, a push overwrote an entry
  ras_unf  out  1  sticky, a pop found RAS empty
  illegal  out  1  registered, reserved pcsrc seen

Function
REQ-005 npc SHALL equal pc + 32'd4 combinationally; carry out discarded (wraps at 2^32).
REQ-006 pcsrc encodings SHALL be CPC=0, NPC=1, REG=2, JAL=3, IMM=4, RAS=5; 6 and 7 are reserved.
REQ-007 When en=1, next pc SHALL be: CPC -> pc; NPC -> npc; REG -> reg_target; JAL -> {npc[31:28], imm26, 2'b00}; IMM -> npc + (imm32 << 2), mod 2^32; RAS -> popped entry.
REQ-008 When en=0, pc, RAS contents, ras_cnt and all flags SHALL hold, regardless of pcsrc.
REQ-009 pcsrc=JAL with en=1 SHALL push npc (the link address) onto the RAS in the same edge that loads the jump target.
REQ-010 Push with ras_cnt < RAS_DEPTH SHALL write at top and increment ras_cnt.
REQ-011 Push with ras_cnt = RAS_DEPTH SHALL overwrite the oldest entry (circular wrap), keep ras_cnt at RAS_DEPTH, and set ras_ovf.
REQ-012 pcsrc=RAS with en=1 and ras_cnt > 0 SHALL load pc from ras_top and decrement ras_cnt.
REQ-013 pcsrc=RAS with en=1 and ras_cnt = 0 SHALL load pc from reg_target, leave ras_cnt at 0, and set ras_unf.
REQ-014 Reserved pcsrc with en=1 SHALL hold pc, leave RAS unchanged, and set illegal for the following cycle only.
REQ-015 flush=1 SHALL set ras_cnt to 0 at the edge, overriding any push/pop that edge; the pc update of that edge SHALL still occur, with RAS-select falling back to reg_target without setting ras_unf.
REQ-016 ras_ovf and ras_unf SHALL stay set until reset; flush SHALL NOT clear them.
REQ-017 ras_top SHALL be combinational from the stack pointer; entries beyond ras_cnt SHALL not be observable.
REQ-018 Latency: pc reflects the selected target one cycle after the enabling edge; no multi-cycle state.

Reset
REQ-019 nRST=0 SHALL immediately, without CLK, force pc=RESET_PC, ras_cnt=0, ras_ovf=0, ras_unf=0, illegal=0.
REQ-020 RAS entry contents need not be reset; ras_top SHALL read 0 while ras_cnt=0.
REQ-021 Reset asserted mid-operation (including during a JAL edge) SHALL win over any update.
REQ-022 First update after nRST rises SHALL occur on the first rising CLK edge with en=1.

Verification
REQ-023 Reset then en=1, pcsrc=NPC for 3 cycles -> pc = 0x0, 0x4, 0x8, 0xC.
REQ-024 pc=0x0040_0010, pcsrc=JAL, imm26=0x0000100 -> pc=0x0000_0400, ras_top=0x0040_0014, ras_cnt=1; then pcsrc=RAS -> pc=0x0040_0014, ras_cnt=0.
REQ-025 RAS_DEPTH=4, five JALs from link addresses A1..A5 -> ras_cnt=4, ras_ovf=1; four pops return A5,A4,A3,A2; a fifth pop with reg_target=0xDEAD_BEE0 -> pc=0xDEAD_BEE0, ras_unf=1.
REQ-026 pc=0x100, pcsrc=IMM, imm32=0xFFFF_FFFE -> pc=0x0FC; pc=0xFFFF_FFFC, pcsrc=NPC -> pc=0x0.
REQ-027 en=0 with pcsrc=JAL for 3 cycles -> pc, ras_cnt unchanged; pcsrc=3'h6, en=1 -> pc held, illegal=1 for one cycle.
REQ-028 ras_cnt=2, flush=1 with pcsrc=RAS, reg_target=0x200 -> pc=0x200, ras_cnt=0, ras_unf=0; nRST pulsed between edges -> pc=RESET_PC immediately.
